// File: rtl/fast_irq_ctrl_if.sv
// Register bus between a core-side master and the fast interrupt controller.
// Signals:
//   req_i    - access request (master -> slave)
//   we_i     - 1 = write, 0 = read
//   be_i     - write byte enables
//   addr_i   - byte address
//   data_i   - write data
//   gnt_o    - access grant (slave -> master)
//   rvalid_o - response valid, one cycle after grant
//   data_o   - read data, 0 for writes and idle cycles
`timescale 1ns/1ps
interface fast_irq_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] data_o;

  modport master (
    output req_i, we_i, be_i, addr_i, data_i,
    input  gnt_o, rvalid_o, data_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, data_i,
    output gnt_o, rvalid_o, data_o
  );
endinterface

// File: rtl/fast_irq_ctrl.sv
// Fast interrupt controller: per-source pending capture (edge or level),
// enable masking and a zero-wait-state register bus.
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous active-high reset
//   src_i      - peripheral interrupt request lines
//   bus        - register bus (fast_irq_ctrl_if.slave)
//   irq_fast_o - PENDING & ENABLE, bit 0 highest priority
// Registers (addr_i[3:2]): 0 ENABLE rw, 1 PENDING r/w1c, 2 TYPE rw
// (1 = rising edge, 0 = level), 3 SET w1s into PENDING, reads 0.
// Build option: define IRQ_SYNC_EN to put a two-flop synchronizer on
// every src_i bit (adds two cycles of latency).
`timescale 1ns/1ps
module fast_irq_ctrl #(
  parameter int unsigned NUM_SRC = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [14:0]         src_i,
  fast_irq_ctrl_if.slave      bus,
  output logic [14:0]         irq_fast_o
);

  localparam int unsigned VEC_W  = 15;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] REG_ENABLE  = 2'd0;
  localparam logic [1:0] REG_PENDING = 2'd1;
  localparam logic [1:0] REG_TYPE    = 2'd2;
  localparam logic [1:0] REG_SET     = 2'd3;

  // Bits at and above NUM_SRC are tied to zero everywhere.
  localparam logic [VEC_W-1:0] SRC_MASK = VEC_W'((32'd1 << NUM_SRC) - 32'd1);

  // Cycles after reset before edge detection may fire: the sample pipeline
  // must hold real src_i history, otherwise a line held high through reset
  // release looks like a rising edge.
`ifdef IRQ_SYNC_EN
  localparam logic [1:0] WARM_CYCLES = 2'd3;
`else
  localparam logic [1:0] WARM_CYCLES = 2'd1;
`endif

  logic [VEC_W-1:0]  enable_q, enable_n;
  logic [VEC_W-1:0]  type_q, type_n;
  logic [VEC_W-1:0]  pending_q, pending_n;
  logic [VEC_W-1:0]  irq_q;
  logic [VEC_W-1:0]  s_d1_q;
  logic [1:0]        warm_q, warm_n;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q, rdata_n;

  logic [VEC_W-1:0]  s;
  logic              armed;
  logic              wr_en;
  logic              rd_en;
  logic [1:0]        sel;
  logic [VEC_W-1:0]  wmask;
  logic [VEC_W-1:0]  wbits;
  logic [VEC_W-1:0]  hw_rise;
  logic [VEC_W-1:0]  w1c;
  logic [VEC_W-1:0]  w1s;
  logic [VEC_W-1:0]  rd_val;

  // Address, data and enable bits outside the decoded fields.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.addr_i[31:4], bus.addr_i[1:0],
                             bus.be_i[3:2], bus.data_i[31:15]};

  // Sampled source vector.
`ifdef IRQ_SYNC_EN
  logic [VEC_W-1:0] sync_q1;
  logic [VEC_W-1:0] sync_q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= src_i & SRC_MASK;
      sync_q2 <= sync_q1;
    end
  end

  assign s = sync_q2;
`else
  assign s = src_i & SRC_MASK;
`endif

  // Every request is granted in the cycle it is made.
  assign bus.gnt_o    = bus.req_i;
  assign bus.rvalid_o = rvalid_q;
  assign bus.data_o   = rdata_q;
  assign irq_fast_o   = irq_q;

  // Next-state: bus decode, register writes and pending update.
  always_comb begin
    wr_en     = bus.req_i & bus.we_i;
    rd_en     = bus.req_i & ~bus.we_i;
    sel       = bus.addr_i[3:2];
    wmask     = {{7{bus.be_i[1]}}, {8{bus.be_i[0]}}} & SRC_MASK;
    wbits     = bus.data_i[VEC_W-1:0] & wmask;
    armed     = (warm_q == WARM_CYCLES);
    warm_n    = armed ? warm_q : warm_q + 2'd1;
    hw_rise   = armed ? (s & ~s_d1_q) : '0;
    w1c       = '0;
    w1s       = '0;
    enable_n  = enable_q;
    type_n    = type_q;
    rd_val    = '0;
    rdata_n   = '0;

    if (wr_en) begin
      unique case (sel)
        REG_ENABLE:  enable_n = (enable_q & ~wmask) | wbits;
        REG_PENDING: w1c      = wbits;
        REG_TYPE:    type_n   = (type_q & ~wmask) | wbits;
        REG_SET:     w1s      = wbits;
        default:     ;
      endcase
    end

    // Edge bits: a new edge or SET wins over a same-cycle clear.
    // Level bits: track the sample; SET forces one cycle of 1.
    // The current TYPE governs, so a TYPE write takes effect next cycle.
    pending_n = ((type_q & (hw_rise | w1s | (pending_q & ~w1c))) |
                 (~type_q & (s | w1s))) & SRC_MASK;

    unique case (sel)
      REG_ENABLE:  rd_val = enable_q;
      REG_PENDING: rd_val = pending_q;
      REG_TYPE:    rd_val = type_q;
      REG_SET:     rd_val = '0;
      default:     rd_val = '0;
    endcase

    if (rd_en) begin
      rdata_n = DATA_W'(rd_val);
    end
  end

  // State registers; irq is registered from the next-state values so it
  // moves on the same edge as PENDING or ENABLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q  <= '0;
      type_q    <= '0;
      pending_q <= '0;
      irq_q     <= '0;
      s_d1_q    <= '0;
      warm_q    <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      enable_q  <= enable_n;
      type_q    <= type_n;
      pending_q <= pending_n;
      irq_q     <= pending_n & enable_n;
      s_d1_q    <= s;
      warm_q    <= warm_n;
      rvalid_q  <= bus.req_i;
      rdata_q   <= rdata_n;
    end
  end

endmodule

// File: tb/tb_fast_irq_ctrl.sv
// Self-checking bench for fast_irq_ctrl: directed scenarios followed by
// random bus/source traffic, checked by a scoreboard against a reference
// model of the register rules.
`timescale 1ns/1ps
module tb_fast_irq_ctrl;

  localparam int NUM_SRC = 15;
`ifdef IRQ_SYNC_EN
  localparam int WARM = 3;
`else
  localparam int WARM = 1;
`endif
  localparam logic [1:0] A_EN   = 2'd0;
  localparam logic [1:0] A_PEND = 2'd1;
  localparam logic [1:0] A_TYPE = 2'd2;
  localparam logic [1:0] A_SET  = 2'd3;

  logic        clk;
  logic        rst;
  logic [14:0] src;
  logic [14:0] irq;

  fast_irq_ctrl_if bus();

  fast_irq_ctrl #(.NUM_SRC(NUM_SRC)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_i      (src),
    .bus        (bus),
    .irq_fast_o (irq)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state and expected-response queue.
  logic [14:0] m_en   = '0;
  logic [14:0] m_pend = '0;
  logic [14:0] m_type = '0;
  logic [14:0] m_prev = '0;
  logic [14:0] m_irq  = '0;
  logic [14:0] m_p1   = '0;
  logic [14:0] m_p2   = '0;
  int          m_age  = 0;
  logic [31:0] sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic report(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One granted cycle; returns 1 time unit after the edge that ends it.
  task automatic access(input logic w, input logic [1:0] a, input logic [31:0] d,
                        input logic [3:0] be);
    logic [31:0] r;
    r = $urandom();
    bus.req_i  = 1'b1;
    bus.we_i   = w;
    bus.addr_i = {r[31:4], a, r[1:0]};
    bus.data_i = d;
    bus.be_i   = be;
    @(posedge clk);
    #1;
    bus.req_i  = 1'b0;
    bus.we_i   = 1'b0;
    bus.be_i   = 4'h0;
  endtask

  // Reference model: register rules applied once per clock.
  initial begin : ref_model
    logic [14:0] s, wm, wv, setb, clrb, vmask;
    logic [31:0] rv;
    vmask = 15'((32'd1 << NUM_SRC) - 32'd1);
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_en = '0; m_pend = '0; m_type = '0; m_prev = '0;
        m_irq = '0; m_p1 = '0; m_p2 = '0; m_age = 0;
        sb.delete();
      end else begin
        s = src & vmask;
`ifdef IRQ_SYNC_EN
        s    = m_p2;
        m_p2 = m_p1;
        m_p1 = src & vmask;
`endif
        wm = '0;
        if (bus.be_i[0]) wm[7:0]  = '1;
        if (bus.be_i[1]) wm[14:8] = '1;
        wm   = wm & vmask;
        wv   = bus.data_i[14:0] & wm;
        setb = '0;
        clrb = '0;
        if (bus.req_i) begin
          if (bus.we_i) begin
            sb.push_back(32'h0);
            if (bus.addr_i[3:2] == A_PEND) clrb = wv;
            if (bus.addr_i[3:2] == A_SET)  setb = wv;
          end else begin
            case (bus.addr_i[3:2])
              A_EN:    rv = {17'b0, m_en};
              A_PEND:  rv = {17'b0, m_pend};
              A_TYPE:  rv = {17'b0, m_type};
              default: rv = 32'h0;
            endcase
            sb.push_back(rv);
          end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
          if (m_type[i]) begin
            if ((s[i] && !m_prev[i] && m_age >= WARM) || setb[i]) m_pend[i] = 1'b1;
            else if (clrb[i]) m_pend[i] = 1'b0;
          end else begin
            m_pend[i] = s[i] | setb[i];
          end
        end
        if (bus.req_i && bus.we_i && bus.addr_i[3:2] == A_EN)   m_en   = (m_en & ~wm) | wv;
        if (bus.req_i && bus.we_i && bus.addr_i[3:2] == A_TYPE) m_type = (m_type & ~wm) | wv;
        m_prev = s;
        if (m_age < WARM) m_age++;
        m_irq = m_pend & m_en;
      end
    end
  end

  // Monitor: compares DUT outputs against the model mid-cycle.
  initial begin : monitor
    logic [31:0] exp_d;
    forever begin
      @(negedge clk);
      report("gnt", {31'b0, bus.gnt_o}, {31'b0, bus.req_i});
      report("rvalid", {31'b0, bus.rvalid_o}, {31'b0, sb.size() != 0});
      if (sb.size() != 0) begin
        exp_d = sb.pop_front();
        if (bus.rvalid_o === 1'b1) report("rdata", bus.data_o, exp_d);
      end else begin
        report("rdata_idle", bus.data_o, 32'h0);
      end
      report("irq", {17'b0, irq}, {17'b0, m_irq});
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] r, d, a;
    rst         = 1'b1;
    src         = '0;
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.be_i    = 4'h0;
    bus.addr_i  = 32'h0;
    bus.data_i  = 32'h0;

    // Reset state.
    #7;
    report("reset_irq", {17'b0, irq}, 32'h0);
    report("reset_rvalid", {31'b0, bus.rvalid_o}, 32'h0);
    report("reset_data", bus.data_o, 32'h0);
    tick(1);
    rst = 1'b0;

    // Byte-enable gating and back-to-back accesses.
    access(1'b1, A_EN, 32'h0000_FFFF, 4'b0001);
    access(1'b0, A_EN, 32'h0, 4'h0);
    report("enable_be_rvalid", {31'b0, bus.rvalid_o}, 32'h1);
    report("enable_be_read", bus.data_o, 32'h0000_00FF);
    access(1'b0, A_PEND, 32'h0, 4'h0);
    access(1'b0, A_TYPE, 32'h0, 4'h0);
    access(1'b1, A_TYPE, 32'h0, 4'hF);
    tick(1);

    // Edge source: pulse latches, W1C clears.
    access(1'b1, A_EN, 32'h1, 4'h3);
    access(1'b1, A_TYPE, 32'h1, 4'h3);
    src[0] = 1'b1;
    tick(1);
    src[0] = 1'b0;
    tick(6);
    report("edge_pulse_held", {17'b0, irq}, 32'h1);
    access(1'b1, A_PEND, 32'h1, 4'h3);
    tick(2);
    report("edge_w1c", {17'b0, irq}, 32'h0);

    // Level source: follows input, W1C ignored.
    access(1'b1, A_TYPE, 32'h0, 4'h3);
    access(1'b1, A_EN, 32'h4000, 4'h3);
    src[14] = 1'b1;
    tick(2);
    access(1'b1, A_PEND, 32'h4000, 4'h3);
    report("level_w1c_ignored", {17'b0, irq}, 32'h4000);
    tick(2);
    src[14] = 1'b0;
    tick(5);

    // Rising edge in the same cycle as a W1C of that bit.
    access(1'b1, A_TYPE, 32'h8, 4'h3);
    src[3] = 1'b1;
    access(1'b1, A_PEND, 32'h8, 4'h3);
    tick(3);
    access(1'b0, A_PEND, 32'h0, 4'h0);
    report("rise_beats_w1c", {31'b0, bus.data_o[3]}, 32'h1);
    src[3] = 1'b0;
    tick(2);

    // SET on an edge bit, SET reads zero.
    access(1'b1, A_EN, 32'h20, 4'h3);
    access(1'b1, A_TYPE, 32'h20, 4'h3);
    access(1'b1, A_SET, 32'h20, 4'h3);
    report("set_irq", {17'b0, irq}, 32'h20);
    access(1'b0, A_SET, 32'h0, 4'h0);
    report("set_reads_zero", bus.data_o, 32'h0);
    tick(1);

    // Reset in the middle of a read with everything pending.
    src = 15'h7FFF;
    access(1'b1, A_TYPE, 32'h7FFF, 4'h3);
    access(1'b1, A_SET, 32'h7FFF, 4'h3);
    access(1'b1, A_EN, 32'h7FFF, 4'h3);
    report("all_pending_irq", {17'b0, irq}, 32'h7FFF);
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = {28'h0, A_PEND, 2'b00};
    #2;
    rst = 1'b1;
    #1;
    report("async_rst_irq", {17'b0, irq}, 32'h0);
    report("async_rst_rvalid", {31'b0, bus.rvalid_o}, 32'h0);
    report("async_rst_data", bus.data_o, 32'h0);
    @(posedge clk);
    #1;
    bus.req_i = 1'b0;
    tick(2);
    rst = 1'b0;
    access(1'b1, A_TYPE, 32'h7FFF, 4'h3);
    access(1'b1, A_PEND, 32'h7FFF, 4'h3);
    tick(3);
    access(1'b0, A_PEND, 32'h0, 4'h0);
    report("no_edge_after_rst", bus.data_o, 32'h0);
    src = '0;
    tick(2);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      r = $urandom();
      d = $urandom();
      a = $urandom();
      rst        = (c == 800);
      src        = src ^ (15'($urandom()) & 15'($urandom()) & 15'($urandom()));
      bus.req_i  = (r[2:0] != 3'd0);
      bus.we_i   = r[3];
      bus.addr_i = {a[31:4], r[5:4], a[1:0]};
      bus.be_i   = r[9:6];
      bus.data_i = d;
      @(posedge clk);
      #1;
    end
    rst       = 1'b0;
    bus.req_i = 1'b0;
    tick(3);
    report("scoreboard_drain", sb.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
